instruction_fetch_stage: RTL

- Fetch stage directly upstream of the opcode decoder/control unit.
- Owns the PC, issues requests to instruction memory over a ready handshake, and holds the IF/ID pipeline register whose opcode field drives the control unit.
- Handles ID-stage stalls with a one-entry capture buffer, and handles branch/jump redirects, including discarding in-flight responses.

---
 rtl/instruction_fetch_stage.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_stage.sv
// ----------------------------------------------------------------------------
// instruction_fetch_stage
//
// Fetch stage feeding the opcode decoder / control unit. It owns the PC,
// issues word-aligned requests to instruction memory, and holds the IF/ID
// pipeline register. A one-entry capture buffer absorbs a response that
// arrives while ID is stalled. Branch/jump redirects flush IF/ID and discard
// any response that belongs to the abandoned path.
//
// Handshake: IMemReq is a request-valid that is never withdrawn, and IMemAddr
// is held stable until it is acknowledged. IMemReady acts as the response
// strobe. A transfer completes on a rising edge where IMemReq=1 and
// IMemReady=1, and IMemData is sampled on that same edge.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   Stall       in   ID busy: IF/ID holds
//   Redirect    in   branch taken / jump resolved in ID
//   RedirectPC  in   redirect target (bits [1:0] ignored)
//   IMemReq     out  instruction memory request
//   IMemAddr    out  request address, word aligned
//   IMemReady   in   response valid this cycle
//   IMemData    in   instruction word, valid with IMemReady
//   Instruction out  IF/ID instruction, 0 when not valid
//   PCPlus4     out  IF/ID instruction address + 4
//   Valid       out  IF/ID holds a real instruction
//   OP          out  Instruction[31:26] for the control unit
//   DbgState    out  current fetch FSM state (debug observation)
// ----------------------------------------------------------------------------
module instruction_fetch_stage #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Redirect,
    input  logic [DATA_WIDTH-1:0] RedirectPC,
    output logic                  IMemReq,
    output logic [DATA_WIDTH-1:0] IMemAddr,
    input  logic                  IMemReady,
    input  logic [DATA_WIDTH-1:0] IMemData,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic [DATA_WIDTH-1:0] PCPlus4,
    output logic                  Valid,
    output logic [5:0]            OP,
    output logic [1:0]            DbgState
);

    // IDLE : first cycle after reset, no request yet
    // REQ  : request for the current PC outstanding
    // FULL : capture buffer occupied, no request
    // DRAIN: a request for an abandoned path is still outstanding
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_FULL  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic                  req_q, req_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pcp4_q, pcp4_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] buf_instr_q, buf_instr_d;
    logic [DATA_WIDTH-1:0] buf_pcp4_q, buf_pcp4_d;

    logic [DATA_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  accept;

    assign target   = {RedirectPC[DATA_WIDTH-1:2], 2'b00};
    assign pc_plus4 = pc_q + DATA_WIDTH'(4);
    assign accept   = req_q & IMemReady;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        req_d       = req_q;
        instr_d     = instr_q;
        pcp4_d      = pcp4_q;
        valid_d     = valid_q;
        buf_instr_d = buf_instr_q;
        buf_pcp4_d  = buf_pcp4_q;

        // Without a stall IF/ID defaults to a bubble; a delivered
        // instruction below overrides it.
        if (!Stall) begin
            instr_d = '0;
            pcp4_d  = '0;
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                req_d   = 1'b1;
                if (Redirect) begin
                    pc_d   = target;
                    addr_d = target;
                end else begin
                    addr_d = pc_q;
                end
            end

            S_REQ: begin
                if (accept) begin
                    if (Redirect) begin
                        // Response belongs to the wrong path: drop it and
                        // start the target fetch right away.
                        pc_d   = target;
                        addr_d = target;
                    end else if (Stall) begin
                        buf_instr_d = IMemData;
                        buf_pcp4_d  = pc_plus4;
                        pc_d        = pc_plus4;
                        addr_d      = pc_plus4;
                        req_d       = 1'b0;
                        state_d     = S_FULL;
                    end else begin
                        instr_d = IMemData;
                        pcp4_d  = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                        addr_d  = pc_plus4;
                    end
                end else if (Redirect) begin
                    // Request cannot be withdrawn; keep the address and
                    // wait for its response to throw it away.
                    pc_d    = target;
                    state_d = S_DRAIN;
                end
            end

            S_FULL: begin
                if (Redirect) begin
                    buf_instr_d = '0;
                    buf_pcp4_d  = '0;
                    pc_d        = target;
                    addr_d      = target;
                    req_d       = 1'b1;
                    state_d     = S_REQ;
                end else if (!Stall) begin
                    instr_d     = buf_instr_q;
                    pcp4_d      = buf_pcp4_q;
                    valid_d     = 1'b1;
                    buf_instr_d = '0;
                    buf_pcp4_d  = '0;
                    addr_d      = pc_q;
                    req_d       = 1'b1;
                    state_d     = S_REQ;
                end
            end

            S_DRAIN: begin
                if (Redirect) begin
                    pc_d = target;
                end
                if (IMemReady) begin
                    // The latest redirect target wins, even one arriving
                    // on the same edge as the stale response.
                    addr_d  = Redirect ? target : pc_q;
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // Redirect flushes IF/ID regardless of Stall.
        if (Redirect) begin
            instr_d = '0;
            pcp4_d  = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            req_q       <= 1'b0;
            instr_q     <= '0;
            pcp4_q      <= '0;
            valid_q     <= 1'b0;
            buf_instr_q <= '0;
            buf_pcp4_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            instr_q     <= instr_d;
            pcp4_q      <= pcp4_d;
            valid_q     <= valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pcp4_q  <= buf_pcp4_d;
        end
    end

    assign IMemReq     = req_q;
    assign IMemAddr    = addr_q;
    assign Instruction = instr_q;
    assign PCPlus4     = pcp4_q;
    assign Valid       = valid_q;
    assign OP          = instr_q[DATA_WIDTH-1 -: 6];
    assign DbgState    = state_q;

endmodule
